// File: rtl/lti_scheduler.sv
// rtl/lti_scheduler.sv - periodic sample scheduler for a clock-enabled LTI system
// Issues ce_start every DIV cycles, captures sys_y on ce_done, flags dropped ticks and missing completions.
module lti_scheduler #(
   parameter int DIV  = 100,
   parameter int LAT  = 4,
   parameter int OW   = 16,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            clr,
   output logic            ce_start,
   input  logic            ce_done,
   input  logic [OW-1:0]   sys_y,
   output logic [OW-1:0]   y_data,
   output logic            y_valid,
   input  logic            y_ready,
   output logic            busy,
   output logic            overrun,
   output logic            timeout,
   output logic [CNTW-1:0] ovr_cnt
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DIV - 1);
   // Watchdog value in the last cycle a late ce_done is still accepted.
   localparam logic [CNTW-1:0] WD_LAST  = CNTW'(LAT + 1);

   logic [0:0]      state;
   logic [CNTW-1:0] cnt;
   logic [CNTW-1:0] wd;
   logic            tick;
   logic            take;
   logic            launch;
   logic            drop;

   assign tick   = en && (cnt == CNT_LAST);
   assign take   = y_valid && y_ready;
   // A handshake on the tick cycle frees the output slot in time for a new launch.
   assign launch = tick && (state == IDLE) && (!y_valid || y_ready);
   assign drop   = tick && ((state == BUSY) || (y_valid && !y_ready));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en || (cnt == CNT_LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         wd       <= '0;
         ce_start <= 1'b0;
         y_valid  <= 1'b0;
         y_data   <= '0;
         timeout  <= 1'b0;
      end else begin
         ce_start <= 1'b0;
         if (take) begin
            y_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (launch) begin
                  state    <= BUSY;
                  busy     <= 1'b1;
                  ce_start <= 1'b1;
                  wd       <= '0;
               end
            end
            BUSY: begin
               if (ce_done) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  y_data  <= sys_y;
                  y_valid <= 1'b1;
               end else if (wd == WD_LAST) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  timeout <= 1'b1;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
         if (clr) begin
            timeout <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
         ovr_cnt <= '0;
      end else if (clr) begin
         overrun <= 1'b0;
         ovr_cnt <= '0;
      end else if (drop) begin
         overrun <= 1'b1;
         if (ovr_cnt != {CNTW{1'b1}}) begin
            ovr_cnt <= ovr_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lti_scheduler.sv
// tb/tb_lti_scheduler.sv - directed self-checking bench for lti_scheduler
module tb_lti_scheduler;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        clr = 1'b0;
   logic        ce_start;
   logic        ce_done;
   logic [15:0] sys_y = 16'h1234;
   logic [15:0] y_data;
   logic        y_valid;
   logic        y_ready = 1'b1;
   logic        busy;
   logic        overrun;
   logic        timeout;
   logic [15:0] ovr_cnt;

   logic        s_rst = 1'b1;
   logic        s_ce_start;
   logic        s_ce_done;
   logic [15:0] s_y_data;
   logic        s_y_valid;
   logic        s_busy;
   logic        s_overrun;
   logic        s_timeout;
   logic [3:0]  s_ovr_cnt;

   logic [3:0]  pipe = 4'd0;
   logic [3:0]  s_pipe = 4'd0;
   logic        model_on = 1'b1;
   logic        force_done = 1'b0;

   int total = 0;
   int bad = 0;

   // System models answer ce_start with ce_done four cycles later.
   always @(posedge clk) begin
      pipe   <= {pipe[2:0], ce_start};
      s_pipe <= {s_pipe[2:0], s_ce_start};
   end
   assign ce_done   = (model_on && pipe[3]) || force_done;
   assign s_ce_done = s_pipe[3];

   lti_scheduler #(.DIV(10), .LAT(4), .OW(16), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .ce_start(ce_start), .ce_done(ce_done), .sys_y(sys_y),
      .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
      .busy(busy), .overrun(overrun), .timeout(timeout), .ovr_cnt(ovr_cnt)
   );

   lti_scheduler #(.DIV(10), .LAT(4), .OW(16), .CNTW(4)) dut_sat (
      .clk(clk), .rst(s_rst), .en(1'b1), .clr(1'b0),
      .ce_start(s_ce_start), .ce_done(s_ce_done), .sys_y(16'h00AA),
      .y_data(s_y_data), .y_valid(s_y_valid), .y_ready(1'b0),
      .busy(s_busy), .overrun(s_overrun), .timeout(s_timeout), .ovr_cnt(s_ovr_cnt)
   );

   task automatic wait_start(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ce_start && n < limit);
      total++;
      if (!ce_start) begin
         bad++;
         $display("FAIL wait_start: ce_start=%b after %0d cycles, expected 1", ce_start, n);
      end
   endtask

   task automatic test_reset();
      int n;
      @(negedge clk);
      #1;
      total++; if ({ce_start, y_valid, busy, overrun, timeout} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b expected 00000", {ce_start, y_valid, busy, overrun, timeout}); end
      total++; if (y_data !== 16'h0) begin bad++; $display("FAIL reset_y_data: got %h expected 0000", y_data); end
      total++; if (ovr_cnt !== 16'h0) begin bad++; $display("FAIL reset_ovr_cnt: got %0d expected 0", ovr_cnt); end
      rst = 1'b0;
      wait_start(30, n);
      total++; if (n !== 10) begin bad++; $display("FAIL reset_first_start: got %0d cycles expected 10", n); end
   endtask

   task automatic test_nominal();
      for (int p = 0; p < 2; p++) begin
         for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            total++; if (y_valid !== (i == 5)) begin bad++; $display("FAIL nom_y_valid p=%0d i=%0d: got %b expected %b", p, i, y_valid, i == 5); end
            total++; if (ce_start !== (i == 10)) begin bad++; $display("FAIL nom_ce_start p=%0d i=%0d: got %b expected %b", p, i, ce_start, i == 10); end
            total++; if (busy !== (i < 5 || i == 10)) begin bad++; $display("FAIL nom_busy p=%0d i=%0d: got %b expected %b", p, i, busy, i < 5 || i == 10); end
            total++; if (overrun !== 1'b0) begin bad++; $display("FAIL nom_overrun p=%0d i=%0d: got %b expected 0", p, i, overrun); end
            if (i == 5) begin
               total++; if (y_data !== 16'h1234) begin bad++; $display("FAIL nom_y_data p=%0d: got %h expected 1234", p, y_data); end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i == 5) begin
            total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL bp_y_valid: got %b expected 1", y_valid); end
            y_ready = 1'b0;
            sys_y = 16'h5555;
         end
         if (i == 10) begin
            total++; if (ce_start !== 1'b0) begin bad++; $display("FAIL bp_dropped_start: got %b expected 0", ce_start); end
         end
         if (i == 15) begin
            total++; if (ovr_cnt !== 16'd1) begin bad++; $display("FAIL bp_ovr_cnt1: got %0d expected 1", ovr_cnt); end
            total++; if (overrun !== 1'b1) begin bad++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
         end
         if (i == 25) begin
            total++; if (ovr_cnt !== 16'd2) begin bad++; $display("FAIL bp_ovr_cnt2: got %0d expected 2", ovr_cnt); end
            total++; if (y_data !== 16'h1234) begin bad++; $display("FAIL bp_y_data_hold: got %h expected 1234", y_data); end
            total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL bp_y_valid_hold: got %b expected 1", y_valid); end
         end
         if (i == 29) begin
            y_ready = 1'b1;
            sys_y = 16'h1234;
         end
         if (i == 30) begin
            total++; if (ce_start !== 1'b1) begin bad++; $display("FAIL bp_coincident_start: got %b expected 1", ce_start); end
            total++; if (ovr_cnt !== 16'd2) begin bad++; $display("FAIL bp_coincident_ovr_cnt: got %0d expected 2", ovr_cnt); end
            total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL bp_y_valid_clear: got %b expected 0", y_valid); end
         end
      end
   endtask

   task automatic test_clear();
      sys_y = 16'h0ABC;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 5) begin
            total++; if (y_data !== 16'h0ABC) begin bad++; $display("FAIL clr_y_data: got %h expected 0abc", y_data); end
            y_ready = 1'b0;
         end
         if (i == 9) clr = 1'b1;
         if (i == 10) begin
            total++; if (overrun !== 1'b0) begin bad++; $display("FAIL clr_overrun: got %b expected 0", overrun); end
            total++; if (ovr_cnt !== 16'd0) begin bad++; $display("FAIL clr_ovr_cnt: got %0d expected 0", ovr_cnt); end
            total++; if (ce_start !== 1'b0) begin bad++; $display("FAIL clr_no_start: got %b expected 0", ce_start); end
            clr = 1'b0;
            y_ready = 1'b1;
         end
         if (i == 20) begin
            total++; if (ce_start !== 1'b1) begin bad++; $display("FAIL clr_next_start: got %b expected 1", ce_start); end
         end
      end
   endtask

   task automatic test_timeout();
      sys_y = 16'h1234;
      model_on = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 5) begin
            total++; if ({busy, timeout} !== 2'b10) begin bad++; $display("FAIL to_before: got busy,timeout=%b expected 10", {busy, timeout}); end
         end
         if (i == 6) begin
            total++; if ({busy, timeout, y_valid} !== 3'b010) begin bad++; $display("FAIL to_fire: got busy,timeout,y_valid=%b expected 010", {busy, timeout, y_valid}); end
         end
         if (i == 7) begin
            clr = 1'b1;
            model_on = 1'b1;
         end
         if (i == 8) begin
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_clr: got %b expected 0", timeout); end
            clr = 1'b0;
         end
         if (i == 10) begin
            total++; if (ce_start !== 1'b1) begin bad++; $display("FAIL to_next_start: got %b expected 1", ce_start); end
         end
      end
   endtask

   task automatic test_done_in_idle();
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 7) begin
            force_done = 1'b1;
            sys_y = 16'hDEAD;
         end
         if (i == 8) begin
            force_done = 1'b0;
            sys_y = 16'h1234;
         end
         if (i == 9) begin
            total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL idle_done_y_valid: got %b expected 0", y_valid); end
            total++; if (y_data !== 16'h1234) begin bad++; $display("FAIL idle_done_y_data: got %h expected 1234", y_data); end
            total++; if (timeout !== 1'b0) begin bad++; $display("FAIL idle_done_timeout: got %b expected 0", timeout); end
         end
         if (i == 10) begin
            total++; if (ce_start !== 1'b1) begin bad++; $display("FAIL idle_done_start: got %b expected 1", ce_start); end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         if (i == 2) begin
            rst = 1'b1;
            #1;
            total++; if ({ce_start, y_valid, busy, overrun, timeout} !== 5'b0) begin bad++; $display("FAIL rmid_flags: got %b expected 00000", {ce_start, y_valid, busy, overrun, timeout}); end
            total++; if (y_data !== 16'h0) begin bad++; $display("FAIL rmid_y_data: got %h expected 0000", y_data); end
         end
         if (i == 3) rst = 1'b0;
         if (i >= 4 && i <= 12) begin
            total++; if ({y_valid, busy, ce_start} !== 3'b000) begin bad++; $display("FAIL rmid_late_done i=%0d: got y_valid,busy,ce_start=%b expected 000", i, {y_valid, busy, ce_start}); end
         end
         if (i == 13) begin
            total++; if (ce_start !== 1'b1) begin bad++; $display("FAIL rmid_restart: got %b expected 1", ce_start); end
         end
      end
   endtask

   task automatic test_en_drop();
      int starts = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (i == 1) en = 1'b0;
         if (i == 5) begin
            total++; if (y_valid !== 1'b1) begin bad++; $display("FAIL en_y_valid: got %b expected 1", y_valid); end
            total++; if (y_data !== 16'h1234) begin bad++; $display("FAIL en_y_data: got %h expected 1234", y_data); end
         end
         if (i >= 6 && ce_start) starts++;
      end
      total++; if (starts !== 0) begin bad++; $display("FAIL en_no_start: got %0d starts expected 0", starts); end
      en = 1'b1;
   endtask

   task automatic test_saturation();
      int starts = 0;
      @(negedge clk);
      s_rst = 1'b0;
      for (int i = 1; i <= 250; i++) begin
         @(negedge clk);
         if (i == 10) begin
            total++; if (s_ce_start !== 1'b1) begin bad++; $display("FAIL sat_first_start: got %b expected 1", s_ce_start); end
         end
         if (i > 10 && s_ce_start) starts++;
         if (i == 150) begin
            total++; if (s_ovr_cnt !== 4'd14) begin bad++; $display("FAIL sat_cnt14: got %0d expected 14", s_ovr_cnt); end
         end
         if (i == 160) begin
            total++; if (s_ovr_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt15: got %0d expected 15", s_ovr_cnt); end
         end
      end
      total++; if (s_ovr_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold: got %0d expected 15", s_ovr_cnt); end
      total++; if (s_overrun !== 1'b1) begin bad++; $display("FAIL sat_overrun: got %b expected 1", s_overrun); end
      total++; if (starts !== 0) begin bad++; $display("FAIL sat_no_start: got %0d starts expected 0", starts); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_clear();
      test_timeout();
      test_done_in_idle();
      test_reset_mid();
      test_en_drop();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lti_scheduler.md
LTI_SCHEDULER -- requirements
Module: lti_scheduler

Interface
REQ-001 SHALL have parameter DIV, default 100: sample period in clk cycles; legal range LAT+3..2^CNTW-1.
REQ-002 SHALL have parameter LAT, default 4: expected cycles from ce_start to ce_done.
REQ-003 SHALL have parameter OW, default 16: sample width.
REQ-004 SHALL have parameter CNTW, default 16: period counter and overrun counter width.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port en, input, 1: enables periodic sampling.
REQ-008 SHALL have port clr, input, 1: synchronous clear of overrun, timeout and ovr_cnt.
REQ-009 SHALL have port ce_start, output, 1: one-cycle strobe to the system clock-enable input.
REQ-010 SHALL have port ce_done, input, 1: completion strobe from the system clock-enable output.
REQ-011 SHALL have port sys_y, input, OW: system output sample.
REQ-012 SHALL have port y_data, output, OW: captured sample.
REQ-013 SHALL have port y_valid, output, 1: y_data is valid.
REQ-014 SHALL have port y_ready, input, 1: downstream accepts the sample.
REQ-015 SHALL have port busy, output, 1: a sample is in flight.
REQ-016 SHALL have port overrun, output, 1: sticky flag set when a period tick was dropped.
REQ-017 SHALL have port timeout, output, 1: sticky flag set when ce_done was missing.
REQ-018 SHALL have port ovr_cnt, output, CNTW: saturating count of dropped ticks.

Function
REQ-019 SHALL implement period counter cnt: when en=1, counts 0..DIV-1 and wraps; tick is asserted when cnt==DIV-1; when en=0, cnt is held at 0 and no tick occurs.
REQ-020 SHALL implement FSM states IDLE and BUSY.
- IDLE: on tick with y_valid=0, assert ce_start for exactly one cycle and go to BUSY.
- BUSY: on ce_done, go to IDLE; at the same edge, y_data<=sys_y and y_valid<=1.
REQ-021 SHALL implement a BUSY watchdog that counts cycles since ce_start.
- If ce_done has not arrived after LAT+2 cycles: set timeout, go to IDLE, leave y_valid unchanged.
REQ-022 SHALL treat a tick as an overrun when it occurs while busy=1 or y_valid=1 and y_ready=0.
- On overrun: suppress ce_start, set overrun, ovr_cnt+=1, with ovr_cnt saturating at 2^CNTW-1.
REQ-023 SHALL handle y_valid and y_ready as follows.
- y_valid clears on the edge where y_valid=1 and y_ready=1.
- If that edge coincides with an IDLE tick, the tick is not an overrun; ce_start is issued that cycle.
REQ-024 SHALL hold y_data stable while y_valid=1 and y_ready=0.
REQ-025 SHALL ignore ce_done while in IDLE: no capture, no flag.
REQ-026 SHALL let an in-flight sample complete normally when en deasserts in BUSY; no further ce_start is issued.
REQ-027 SHALL give clr priority over a simultaneous set of overrun or timeout: flags clear and ovr_cnt=0 that edge.
REQ-028 SHALL drive busy from a register and not from combinational logic on inputs; it is 1 exactly while FSM=BUSY.
REQ-029 SHALL give end-to-end latency from ce_start to y_valid of LAT+1 cycles when ce_done arrives at LAT.

Reset
REQ-030 SHALL, while rst=1, asynchronously force: FSM=IDLE, cnt=0, watchdog=0, ce_start=0, y_valid=0, y_data=0, busy=0, overrun=0, timeout=0, ovr_cnt=0.
REQ-031 SHALL, when rst is asserted mid-operation, discard the in-flight sample; a later ce_done is ignored per REQ-025.
REQ-032 SHALL, after rst deassertion with en=1, issue the first ce_start DIV cycles later.

Verification
REQ-033 SHALL cover nominal operation: DIV=10, LAT=4, en=1, y_ready=1, system model echoes ce_done 4 cycles after ce_start with sys_y=16'h1234 -> ce_start every 10 cycles, y_valid for 1 cycle 5 cycles after each ce_start, y_data=16'h1234, overrun=0.
REQ-034 SHALL cover backpressure: y_ready=0 for 25 cycles after the first y_valid -> 2 ticks dropped, ovr_cnt=2, overrun=1, y_data unchanged; y_ready=1 -> next tick issues ce_start.
REQ-035 SHALL cover timeout: ce_done never returned -> timeout=1 exactly LAT+2 cycles after ce_start, busy=0, next tick issues ce_start.
REQ-036 SHALL cover simultaneous events: y_ready handshake on the same cycle as a tick -> ce_start issued, ovr_cnt unchanged; clr coincident with an overrun tick -> overrun=0, ovr_cnt=0.
REQ-037 SHALL cover reset and enable: rst pulsed 2 cycles after ce_start -> all outputs 0 immediately, late ce_done ignored, y_valid stays 0; en dropped in BUSY -> sample delivered, no further ce_start.
REQ-038 SHALL cover saturation: CNTW=4 with y_ready held 0 for 20 ticks -> ovr_cnt=15 and holds.
